// File: rtl/if_fetch_if.sv
// Fetch-unit bundle: redirect/stall controls from the pipeline, ROM read port and
// the PC/instruction pair presented to IF/ID.
interface if_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  jump_flag_i;
  logic [ADDR_WIDTH-1:0] jump_addr_i;
  logic                  hold_i;
  logic [ADDR_WIDTH-1:0] rom_addr_o;
  logic                  rom_en_o;
  logic [DATA_WIDTH-1:0] rom_data_i;
  logic [ADDR_WIDTH-1:0] pc_o;
  logic [DATA_WIDTH-1:0] inst_o;
  logic                  valid_o;

  modport master (
    input  jump_flag_i,
    input  jump_addr_i,
    input  hold_i,
    input  rom_data_i,
    output rom_addr_o,
    output rom_en_o,
    output pc_o,
    output inst_o,
    output valid_o
  );

  modport slave (
    output jump_flag_i,
    output jump_addr_i,
    output hold_i,
    output rom_data_i,
    input  rom_addr_o,
    input  rom_en_o,
    input  pc_o,
    input  inst_o,
    input  valid_o
  );
endinterface

// File: rtl/if_fetch.sv
// J1-style instruction fetch: PC, one-cycle ROM, one-entry skid buffer, jump redirect.
// Optional FETCH_PERF_CNT_EN adds saturating accepted-instruction and bubble counters.
module if_fetch #(
  parameter int unsigned           ADDR_WIDTH = 13,
  parameter int unsigned           DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] INST_NOP   = DATA_WIDTH'(16'h6000)
) (
  input  logic        clk,
  input  logic        rst,
  if_fetch_if.master  bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  typedef enum logic [1:0] {StRun, StStall, StRedirect} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  logic                  infl_q;
  logic [ADDR_WIDTH-1:0] infl_pc_q;
  logic                  buf_v_q;
  logic [ADDR_WIDTH-1:0] buf_pc_q;
  logic [DATA_WIDTH-1:0] buf_inst_q;

  logic                  jump;
  logic                  hold;
  logic                  issue;
  logic                  valid;
  logic                  accept;
  logic                  capture;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] inst;

  assign jump = bus.jump_flag_i;
  assign hold = bus.hold_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (jump) begin
      state_d = StRedirect;
    end else begin
      unique case (state_q)
        StRun:      if (capture) state_d = StStall;
        StStall:    if (accept)  state_d = StRun;
        StRedirect: if (!hold)   state_d = StRun;
        default:                 state_d = StRun;
      endcase
    end
  end

  always_comb begin
    // Reset gating keeps the ROM idle while rst is held, not just after the edge.
    issue   = !rst && !jump && !hold;
    valid   = (buf_v_q || infl_q) && !jump;
    accept  = valid && !hold;
    capture = hold && !jump && infl_q && !buf_v_q;
    pc      = '0;
    inst    = INST_NOP;
    if (valid) begin
      if (buf_v_q) begin
        pc   = buf_pc_q;
        inst = buf_inst_q;
      end else begin
        pc   = infl_pc_q;
        inst = bus.rom_data_i;
      end
    end
  end

  assign bus.rom_addr_o = fetch_pc_q;
  assign bus.rom_en_o   = issue;
  assign bus.valid_o    = valid;
  assign bus.pc_o       = pc;
  assign bus.inst_o     = inst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      infl_q     <= 1'b0;
      infl_pc_q  <= '0;
      buf_v_q    <= 1'b0;
      buf_pc_q   <= '0;
      buf_inst_q <= INST_NOP;
    end else if (jump) begin
      fetch_pc_q <= bus.jump_addr_i;
      infl_q     <= 1'b0;
      buf_v_q    <= 1'b0;
    end else begin
      infl_q <= issue;
      if (issue) begin
        infl_pc_q  <= fetch_pc_q;
        fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(1);
      end
      // No issue happens under hold, so only the word already in flight can land here.
      if (capture) begin
        buf_v_q    <= 1'b1;
        buf_pc_q   <= infl_pc_q;
        buf_inst_q <= bus.rom_data_i;
      end else if (accept && buf_v_q) begin
        buf_v_q <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (accept && (fetch_cnt_q != '1)) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (!valid && !hold && (bubble_cnt_q != '1)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt_o  = fetch_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: stimulus queues expected PC/instruction pairs,
// a negedge monitor pops and compares every accepted output.
module tb_if_fetch;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 16;
  localparam logic [DW-1:0] NOP = 16'h6000;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  if_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fb ();
  if_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fw ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt, fetch_cnt_w, bubble_cnt_w;
`endif

  if_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(13'h0000)) dut (
    .clk(clk),
    .rst(rst),
    .bus(fb)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o(fetch_cnt),
    .bubble_cnt_o(bubble_cnt)
`endif
  );

  if_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(13'h1FFE)) dut_wrap (
    .clk(clk),
    .rst(rst),
    .bus(fw)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o(fetch_cnt_w),
    .bubble_cnt_o(bubble_cnt_w)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM contents: ROM[i] = i + 0x100.
  always @(posedge clk) begin
    if (fb.rom_en_o) fb.rom_data_i <= 16'h0100 + 16'(fb.rom_addr_o);
    if (fw.rom_en_o) fw.rom_data_i <= 16'h0100 + 16'(fw.rom_addr_o);
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void push_exp(input logic [AW-1:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = 16'h0100 + 16'(pc);
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && fb.valid_o && !fb.hold_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got pc %h with nothing expected", fb.pc_o);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", 32'(fb.pc_o), 32'(e.pc));
        check("sb_inst", 32'(fb.inst_o), 32'(e.inst));
      end
    end
  end

  task automatic cyc(input logic h, input logic j, input logic [AW-1:0] a);
    @(posedge clk);
    #1;
    fb.hold_i      = h;
    fb.jump_flag_i = j;
    fb.jump_addr_i = a;
    @(negedge clk);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst            = 1'b0;
    fb.hold_i      = 1'b0;
    fb.jump_flag_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [AW-1:0] wrap_exp [4];
    wrap_exp[0] = 13'h1FFE;
    wrap_exp[1] = 13'h1FFF;
    wrap_exp[2] = 13'h0000;
    wrap_exp[3] = 13'h0001;
    checks = 0;
    errors = 0;
    rst            = 1'b1;
    fb.hold_i      = 1'b0;
    fb.jump_flag_i = 1'b0;
    fb.jump_addr_i = '0;
    fw.hold_i      = 1'b0;
    fw.jump_flag_i = 1'b0;
    fw.jump_addr_i = '0;

    repeat (2) @(negedge clk);
    check("rst_rom_en", 32'(fb.rom_en_o), 32'd0);
    check("rst_valid", 32'(fb.valid_o), 32'd0);
    check("rst_pc", 32'(fb.pc_o), 32'd0);
    check("rst_inst", 32'(fb.inst_o), 32'(NOP));

    // Expected accepted stream for the first run.
    for (int i = 0; i <= 16; i++) push_exp(AW'(i));
    push_exp(13'h0A0);
    push_exp(13'h0A1);
    push_exp(13'h150);
    push_exp(13'h151);
    push_exp(13'h152);

    release_rst();
    check("c0_valid", 32'(fb.valid_o), 32'd0);
    check("c0_rom_en", 32'(fb.rom_en_o), 32'd1);
    check("c0_rom_addr", 32'(fb.rom_addr_o), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, 1'b0, '0);
      if (i <= 4) check("wrap_pc", 32'(fw.pc_o), 32'(wrap_exp[i-1]));
    end

    // Stall three cycles while pc 5 is presented.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, '0);
      check("stall_valid", 32'(fb.valid_o), 32'd1);
      check("stall_pc", 32'(fb.pc_o), 32'h5);
      check("stall_inst", 32'(fb.inst_o), 32'h0105);
      check("stall_rom_en", 32'(fb.rom_en_o), 32'd0);
    end
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, '0);

    // Jump after pc 0x010 has been delivered.
    cyc(1'b0, 1'b1, 13'h0A0);
    check("jmp_bubble0", 32'(fb.valid_o), 32'd0);
    cyc(1'b0, 1'b0, '0);
    check("jmp_bubble1", 32'(fb.valid_o), 32'd0);
    check("jmp_rom_addr", 32'(fb.rom_addr_o), 32'h0A0);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);

    // Fill the skid buffer, then jump while still held.
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 13'h150);
    check("jh_valid", 32'(fb.valid_o), 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, '0);
      check("jh_hold_valid", 32'(fb.valid_o), 32'd0);
      check("jh_hold_rom_en", 32'(fb.rom_en_o), 32'd0);
    end
    cyc(1'b0, 1'b0, '0);
    check("jh_issue_valid", 32'(fb.valid_o), 32'd0);
    check("jh_issue_addr", 32'(fb.rom_addr_o), 32'h150);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0);

    // Async reset in the middle of a stall.
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(fb.valid_o), 32'd0);
    check("arst_pc", 32'(fb.pc_o), 32'd0);
    check("arst_inst", 32'(fb.inst_o), 32'(NOP));
    check("arst_rom_en", 32'(fb.rom_en_o), 32'd0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 10; i++) push_exp(AW'(i));
    push_exp(13'h040);
    release_rst();
    check("rst2_rom_addr", 32'(fb.rom_addr_o), 32'd0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 13'h040);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch", fetch_cnt, 32'd10);
    check("perf_bubble", bubble_cnt, 32'd3);
`endif
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, '0);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch unit for the J1-style stack CPU. It owns the program counter, drives a synchronous instruction ROM (one-cycle read latency) and presents a PC/instruction pair to the IF/ID pipeline register. It honours downstream stalls through a one-entry skid buffer and redirects on jumps signalled by EX. In-flight and buffered fetches are discarded on a redirect.

## Interface
- ADDR_WIDTH, 13, instruction address width (8K-word ROM max)
- DATA_WIDTH, 16, instruction width
- RESET_PC, 0, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- jump_flag_i  in  1  redirect request from EX, single-cycle pulse
- jump_addr_i  in  ADDR_WIDTH  redirect target, sampled when jump_flag_i=1
- hold_i  in  1  downstream cannot accept the current output this cycle
- rom_addr_o  out  ADDR_WIDTH  ROM read address (registered fetch PC)
- rom_en_o  out  1  ROM read enable; data valid on rom_data_i next cycle
- rom_data_i  in  DATA_WIDTH  ROM read data
- pc_o  out  ADDR_WIDTH  address of inst_o
- inst_o  out  DATA_WIDTH  fetched instruction; INST_NOP (shared defines) when valid_o=0
- valid_o  out  1  pc_o/inst_o carry a real instruction

## Operation
- Registers:
  - fetch_pc (next address to issue)
  - infl (a read issued last cycle is returning now) and infl_pc
  - buf_v, buf_pc, buf_inst (skid entry)
  - state
- States:
  - RUN: buf empty.
  - STALL: buf_v=1.
  - REDIRECT: the cycle after a jump, with nothing in flight.
- rom_addr_o = fetch_pc. rom_en_o = !jump_flag_i && !hold_i.
- On issue (rom_en_o=1): infl<=1, infl_pc<=fetch_pc, fetch_pc<=fetch_pc+1. The increment wraps modulo 2^ADDR_WIDTH (all-ones -> 0).
- No issue: infl<=0, fetch_pc unchanged.
- Output select: if buf_v, drive buf_pc/buf_inst; else if infl, drive infl_pc/rom_data_i; else pc_o=0, inst_o=INST_NOP.
- valid_o = (buf_v || infl) && !jump_flag_i.
- Accept = valid_o && !hold_i. On accept of the buffer entry, buf_v<=0 (STALL->RUN).
- hold_i=1 with infl=1 and buf_v=0: capture rom_data_i/infl_pc into the buffer (RUN->STALL). No issue occurs during hold, so at most one word arrives and the buffer cannot overflow.
- hold_i=1 with buf_v=1: the buffer holds and outputs stay stable.
- jump_flag_i=1, in any state, has priority over hold_i:
  - buf_v<=0, infl<=0, fetch_pc<=jump_addr_i, no issue, state->REDIRECT.
  - REDIRECT issues jump_addr_i the next cycle (if !hold_i), then ->RUN.
- A jump in REDIRECT re-targets to the newer jump_addr_i.
- hold_i in REDIRECT: stay in REDIRECT, no issue.

## Timing
- Reset (async assert; outputs immediately): fetch_pc=RESET_PC, infl=0, buf_v=0, state=RUN, rom_en_o=0, valid_o=0, pc_o=0, inst_o=INST_NOP.
- First cycle after reset release: issue RESET_PC. The first valid_o is one cycle later.
- Steady state: one instruction per cycle. Latency from issue to valid_o is 1 cycle.
- Jump penalty: jump cycle plus issue cycle give 2 bubble cycles. The target instruction is valid 2 cycles after the jump_flag_i cycle.
- Stall: outputs are frozen while hold_i=1. The first cycle after hold_i falls delivers the buffered word and issues the next address, with no bubble.
- Reset mid-stall or mid-redirect: all pending state is dropped and fetch restarts at RESET_PC.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - Adds outputs fetch_cnt_o[31:0] (accepted instructions) and bubble_cnt_o[31:0] (cycles with valid_o=0 and hold_i=0).
  - Both counters reset to 0 and saturate at all-ones.
- Not defined: these ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Reset release, hold_i=0, ROM[i]=i+0x100 -> valid_o rises on cycle 2; pc_o 0,1,2… and inst_o 0x0100,0x0101… on consecutive cycles.
- hold_i high 3 cycles while pc_o=5 -> pc_o=5/inst_o=ROM[5] stable throughout, rom_en_o=0. The cycle after release delivers pc 5, then 6, with no gap or duplicate.
- jump_flag_i=1, jump_addr_i=0x0A0 while running at pc 0x010 -> valid_o=0 for 2 cycles, then pc_o=0x0A0 with ROM[0x0A0]. Words 0x011/0x012 never appear.
- jump_flag_i and hold_i asserted together while buf_v=1 -> buffer discarded, redirect taken. The target appears 2 cycles after hold_i drops.
- RESET_PC=0x1FFE, ADDR_WIDTH=13 -> pc_o sequence 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- With FETCH_PERF_CNT_EN: 10 accepts plus one jump -> fetch_cnt_o=10, bubble_cnt_o=2 (plus the 1 reset-exit bubble, 3 total).
